mouse_pos_ctl: RTL and testbench
================================

Name: mouse_pos_ctl

Overview:
- Sequences cursor-position updates into the mouse-overlay draw stage of the VGA pipeline. Updates are committed only at the start of vertical blanking, so the cursor never tears mid-frame.
- Arbitrates between two position sources:
  - the PS/2 mouse controller (absolute position, valid strobe);
  - game logic "warp" requests (e.g. re-centre the cursor at a new penalty round), which have priority.
- Also produces a frame-aligned left-click event pulse for the game FSM.

Parameters:
- H_MAX, 799, largest legal committed xpos (800x600 timing)
- V_MAX, 599, largest legal committed ypos
- X_RST, 400, xpos value after reset
- Y_RST, 300, ypos value after reset

Ports:
- clk  in  1  pixel clock, 40 MHz domain
- rst  in  1  synchronous, active-high reset
- vblnk  in  1  vertical blank from the timing pipeline, registered
- ms_xpos  in  12  mouse absolute x
- ms_ypos  in  12  mouse absolute y
- ms_valid  in  1  one-cycle strobe; ms_xpos/ms_ypos are valid in that cycle
- ms_left  in  1  left-button level, already in clk domain
- warp_req  in  1  level; held until warp_ack
- warp_x  in  12  warp target x, stable while warp_req is high
- warp_y  in  12  warp target y, stable while warp_req is high
- warp_ack  out  1  one-cycle pulse when the warp is committed
- xpos  out  12  committed cursor x, to the overlay stage
- ypos  out  12  committed cursor y, to the overlay stage
- click  out  1  one-cycle pulse, left-click event
- frame_tick  out  1  one-cycle pulse per commit
- busy  out  1  high while a warp is pending and not yet acked

Behaviour:
- Reset values: xpos=X_RST, ypos=Y_RST; warp_ack=click=frame_tick=busy=0; pending registers cleared; FSM in ACTIVE; vblnk_d=1.
  - vblnk_d=1 prevents a spurious commit when vblnk is high during the first cycle after reset.
- Pending capture, any state:
  - ms_valid=1 loads pend_x/pend_y and sets pend_v.
  - Last strobe before a commit wins.
  - A strobe in the COMMIT cycle itself is kept for the next frame.
- FSM states:
  - ACTIVE: wait for the vblnk rising edge (vblnk=1 and vblnk_d=0), then go to COMMIT.
  - COMMIT, exactly 1 cycle:
    - If warp_req=1: xpos/ypos take the clamped warp_x/warp_y; warp_ack=1; pend_v is cleared, so the mouse sample is discarded.
    - Else if pend_v=1: xpos/ypos take the clamped pend_x/pend_y; pend_v is cleared.
    - Else: xpos/ypos hold.
    - frame_tick=1. Next state is BLANK.
  - BLANK: wait for vblnk=0, then go to ACTIVE.
- Timing: registered outputs change on the clock edge following the COMMIT cycle, i.e. latency from the vblnk rising edge to the new xpos is 2 clk.
- Clamp rule: value > H_MAX (resp. V_MAX) is saturated to H_MAX (resp. V_MAX). Inputs are unsigned, so there is no lower clamp.
- busy = warp_req & ~warp_ack, registered.
  - warp_req dropped before ack: the request is abandoned, no ack is issued, busy falls next cycle.
- Click:
  - ms_left is sampled only in COMMIT into left_q.
  - click=1 in the cycle after COMMIT when the sample is 1 and left_q was 0.
  - At most one click per frame.
- Reset mid-frame: FSM returns to ACTIVE with vblnk_d=1; the first commit happens at the next vblnk rising edge.
- Simultaneous warp_req rise and vblnk rise: the warp is taken in that same frame's COMMIT.
- vblnk pulse of only 1 cycle: COMMIT still executes; BLANK exits on the next cycle if vblnk=0.

Optional Feature:
- Macro: MOUSE_CLICK_DEBOUNCE_EN.
- Defined: click requires ms_left=1 at two consecutive COMMIT samples, preceded by a 0 sample. The pulse is delayed by one frame, which rejects single-frame glitches.
- Undefined: single-sample edge detection as described above.

Decomposition:
- vga_pkg:
  - H_MAX/V_MAX defaults, shared with the timing generator;
  - typedef enum logic [1:0] {ACTIVE, COMMIT, BLANK} mouse_ctl_state_t;
  - a 12-bit position typedef pos_t.
- Sub-module mouse_pos_clamp: combinational saturating clamp. It is instantiated twice, once for x and once for y, on the mux output feeding xpos/ypos.
- draw_mouse consumes xpos/ypos; nothing else changes in the overlay stage.

Test Plan:
- Reset then idle frames → xpos=400, ypos=300; one frame_tick per vblnk rise; no click.
- Mid-frame ms_valid (120,80) then (130,90), then vblnk rise → xpos=130, ypos=90, 2 clk after the edge. No change before vblank.
- ms_valid (1000,700) → committed xpos=799, ypos=599.
- warp_req (400,300) held together with ms_valid (50,50) in the same frame → commit (400,300); warp_ack is 1 cycle in COMMIT; busy high until then; the mouse sample is discarded.
- ms_left high across 3 frames → exactly one click pulse (frame 1; frame 2 with MOUSE_CLICK_DEBOUNCE_EN). A 1-frame glitch yields 0 clicks only with the macro.
- rst asserted during BLANK with pend_v set → outputs at reset values; pending cleared; next commit only at the next vblnk rising edge.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA pipeline types and 800x600 limits, used by the timing generator and
// the mouse-overlay front end.
package vga_pkg;

    localparam int unsigned VGA_H_MAX = 799;
    localparam int unsigned VGA_V_MAX = 599;
    localparam int unsigned VGA_X_RST = 400;
    localparam int unsigned VGA_Y_RST = 300;

    typedef logic [11:0] pos_t;

    typedef enum logic [1:0] {
        ACTIVE,
        COMMIT,
        BLANK
    } mouse_ctl_state_t;

endpackage

// File: rtl/mouse_pos_clamp.sv
// Combinational saturating clamp for one 12-bit unsigned cursor coordinate.
module mouse_pos_clamp
    import vga_pkg::*;
#(
    parameter pos_t MAX = 12'd799
) (
    input  logic [11:0] val_i,
    output logic [11:0] clamped_o
);

    assign clamped_o = (val_i > MAX) ? MAX : val_i;

endmodule

// File: rtl/mouse_pos_ctl.sv
// Frame-aligned cursor position sequencer: commits mouse/warp updates at vblank start.
// Optional macro MOUSE_CLICK_DEBOUNCE_EN: click needs two consecutive frame samples high.
module mouse_pos_ctl
    import vga_pkg::*;
#(
    parameter int unsigned H_MAX = VGA_H_MAX,
    parameter int unsigned V_MAX = VGA_V_MAX,
    parameter int unsigned X_RST = VGA_X_RST,
    parameter int unsigned Y_RST = VGA_Y_RST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic [11:0] ms_xpos,
    input  logic [11:0] ms_ypos,
    input  logic        ms_valid,
    input  logic        ms_left,
    input  logic        warp_req,
    input  logic [11:0] warp_x,
    input  logic [11:0] warp_y,
    output logic        warp_ack,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        click,
    output logic        frame_tick,
    output logic        busy
);

    mouse_ctl_state_t state_q, state_d;

    logic       vblnk_q;
    pos_t       pend_x_q, pend_y_q;
    logic       pend_v_q;
    pos_t       xpos_q, ypos_q;
    logic       busy_q;
    logic       click_q;
    logic       left_q;
    logic       commit;
    logic       click_d;
    pos_t       sel_x, sel_y;
    pos_t       clamp_x, clamp_y;

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            ACTIVE: if (vblnk && !vblnk_q) state_d = COMMIT;
            COMMIT: begin
                commit  = 1'b1;
                state_d = BLANK;
            end
            BLANK:  if (!vblnk) state_d = ACTIVE;
            default: state_d = ACTIVE;
        endcase
    end

    // Warp has priority over the buffered mouse sample.
    assign sel_x = warp_req ? warp_x : pend_x_q;
    assign sel_y = warp_req ? warp_y : pend_y_q;

    mouse_pos_clamp #(.MAX(pos_t'(H_MAX))) u_clamp_x (
        .val_i     (sel_x),
        .clamped_o (clamp_x)
    );

    mouse_pos_clamp #(.MAX(pos_t'(V_MAX))) u_clamp_y (
        .val_i     (sel_y),
        .clamped_o (clamp_y)
    );

`ifdef MOUSE_CLICK_DEBOUNCE_EN
    logic left2_q;
    assign click_d = ms_left & left_q & ~left2_q;
`else
    assign click_d = ms_left & ~left_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACTIVE;
            vblnk_q  <= 1'b1;
            pend_x_q <= '0;
            pend_y_q <= '0;
            pend_v_q <= 1'b0;
            xpos_q   <= pos_t'(X_RST);
            ypos_q   <= pos_t'(Y_RST);
            busy_q   <= 1'b0;
            click_q  <= 1'b0;
            left_q   <= 1'b0;
`ifdef MOUSE_CLICK_DEBOUNCE_EN
            left2_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            vblnk_q <= vblnk;
            busy_q  <= warp_req & ~warp_ack;
            click_q <= 1'b0;
            if (commit) begin
                if (warp_req || pend_v_q) begin
                    xpos_q <= clamp_x;
                    ypos_q <= clamp_y;
                end
                left_q  <= ms_left;
                click_q <= click_d;
`ifdef MOUSE_CLICK_DEBOUNCE_EN
                left2_q <= left_q;
`endif
            end
            // A strobe landing in the commit cycle survives for the next frame.
            if (ms_valid) begin
                pend_x_q <= ms_xpos;
                pend_y_q <= ms_ypos;
                pend_v_q <= 1'b1;
            end else if (commit) begin
                pend_v_q <= 1'b0;
            end
        end
    end

    assign warp_ack   = commit & warp_req;
    assign frame_tick = commit;
    assign xpos       = xpos_q;
    assign ypos       = ypos_q;
    assign click      = click_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mouse_pos_ctl.sv
// Self-checking bench for mouse_pos_ctl with a frame-level reference model.
module tb_mouse_pos_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblnk;
    logic [11:0] ms_xpos, ms_ypos;
    logic        ms_valid;
    logic        ms_left;
    logic        warp_req;
    logic [11:0] warp_x, warp_y;
    logic        warp_ack;
    logic [11:0] xpos, ypos;
    logic        click;
    logic        frame_tick;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int clicks = 0;

    // Frame-level model state
    int mx = 400, my = 300;
    int px = 0, py = 0;
    bit pv = 0;
    bit s1 = 0, s2 = 0;

    always #5 clk = ~clk;

    mouse_pos_ctl dut (
        .clk        (clk),
        .rst        (rst),
        .vblnk      (vblnk),
        .ms_xpos    (ms_xpos),
        .ms_ypos    (ms_ypos),
        .ms_valid   (ms_valid),
        .ms_left    (ms_left),
        .warp_req   (warp_req),
        .warp_x     (warp_x),
        .warp_y     (warp_y),
        .warp_ack   (warp_ack),
        .xpos       (xpos),
        .ypos       (ypos),
        .click      (click),
        .frame_tick (frame_tick),
        .busy       (busy)
    );

    function automatic int clampi(int v, int m);
        return (v > m) ? m : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_commit(bit warp, int wx, int wy, bit left);
        bit c;
        if (warp) begin
            mx = clampi(wx, 799);
            my = clampi(wy, 599);
            pv = 0;
        end else if (pv) begin
            mx = clampi(px, 799);
            my = clampi(py, 599);
            pv = 0;
        end
`ifdef MOUSE_CLICK_DEBOUNCE_EN
        c = left && s1 && !s2;
`else
        c = left && !s1;
`endif
        s2 = s1;
        s1 = left;
        return c;
    endfunction

    task automatic strobe(int x, int y);
        ms_valid = 1'b1;
        ms_xpos  = 12'(x);
        ms_ypos  = 12'(y);
        tick();
        ms_valid = 1'b0;
        px = x;
        py = y;
        pv = 1;
        chk("hold_x", xpos, mx);
        chk("hold_y", ypos, my);
        chk("no_tick", frame_tick, 0);
    endtask

    task automatic frame(bit warp, int wx, int wy, int nstrobe, bit left, bit one_cyc, bit cstrobe);
        bit ec;
        int cx, cy;
        ms_left = left;
        if (warp) begin
            warp_req = 1'b1;
            warp_x   = 12'(wx);
            warp_y   = 12'(wy);
        end
        tick();
        chk("busy_pending", busy, warp);
        for (int i = 0; i < nstrobe; i++)
            strobe(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
        tick();
        tick();
        vblnk = 1'b1;
        tick();
        chk("commit_tick", frame_tick, 1);
        chk("commit_ack", warp_ack, warp);
        chk("commit_busy", busy, warp);
        chk("pre_x", xpos, mx);
        chk("pre_y", ypos, my);
        if (one_cyc) vblnk = 1'b0;
        cx = int'($urandom_range(0, 4095));
        cy = int'($urandom_range(0, 4095));
        if (cstrobe) begin
            ms_valid = 1'b1;
            ms_xpos  = 12'(cx);
            ms_ypos  = 12'(cy);
        end
        tick();
        ms_valid = 1'b0;
        ec = model_commit(warp, wx, wy, left);
        if (cstrobe) begin
            px = cx;
            py = cy;
            pv = 1;
        end
        chk("post_x", xpos, mx);
        chk("post_y", ypos, my);
        chk("post_click", click, ec);
        if (click === 1'b1) clicks++;
        chk("post_tick", frame_tick, 0);
        chk("post_ack", warp_ack, 0);
        chk("post_busy", busy, 0);
        warp_req = 1'b0;
        if (!one_cyc) begin
            repeat (3) tick();
            chk("blank_tick", frame_tick, 0);
            vblnk = 1'b0;
            tick();
        end
        tick();
        chk("idle_click", click, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        bit dummy;
        int c0;
        rst      = 1'b1;
        vblnk    = 1'b1;
        ms_xpos  = '0;
        ms_ypos  = '0;
        ms_valid = 1'b0;
        ms_left  = 1'b0;
        warp_req = 1'b0;
        warp_x   = '0;
        warp_y   = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_x", xpos, 400);
        chk("rst_y", ypos, 300);
        chk("rst_ack", warp_ack, 0);
        chk("rst_click", click, 0);
        chk("rst_tick", frame_tick, 0);
        chk("rst_busy", busy, 0);
        repeat (3) begin
            tick();
            chk("rst_vblnk_hi_tick", frame_tick, 0);
        end
        vblnk = 1'b0;
        tick();

        // Idle frames keep the reset position
        frame(0, 0, 0, 0, 0, 0, 0);
        frame(0, 0, 0, 0, 0, 0, 0);

        // Last strobe before commit wins
        strobe(120, 80);
        strobe(130, 90);
        frame(0, 0, 0, 0, 0, 0, 0);
        chk("last_wins_x", xpos, 130);

        // Saturation
        strobe(1000, 700);
        frame(0, 0, 0, 0, 0, 0, 0);
        chk("sat_x", xpos, 799);
        chk("sat_y", ypos, 599);

        // Warp beats mouse, mouse sample discarded
        strobe(50, 50);
        frame(1, 400, 300, 0, 0, 0, 0);
        frame(0, 0, 0, 0, 0, 0, 0);
        chk("warp_discard_x", xpos, 400);

        // Abandoned warp
        warp_req = 1'b1;
        warp_x   = 12'd10;
        warp_y   = 12'd10;
        tick();
        chk("abandon_busy_hi", busy, 1);
        warp_req = 1'b0;
        tick();
        chk("abandon_busy_lo", busy, 0);
        frame(0, 0, 0, 0, 0, 0, 0);

        // Left held over three frames
        c0 = clicks;
        frame(0, 0, 0, 0, 1, 0, 0);
        frame(0, 0, 0, 0, 1, 0, 0);
        frame(0, 0, 0, 0, 1, 0, 0);
        chk("held_clicks", clicks - c0, 1);
        frame(0, 0, 0, 0, 0, 0, 0);
        frame(0, 0, 0, 0, 0, 0, 0);

        // Single-frame glitch
        c0 = clicks;
        frame(0, 0, 0, 0, 1, 0, 0);
        frame(0, 0, 0, 0, 0, 0, 0);
        frame(0, 0, 0, 0, 0, 0, 0);
`ifdef MOUSE_CLICK_DEBOUNCE_EN
        chk("glitch_clicks", clicks - c0, 0);
`else
        chk("glitch_clicks", clicks - c0, 1);
`endif

        // One-cycle vblank pulse and strobe in the commit cycle
        strobe(200, 150);
        frame(0, 0, 0, 0, 0, 1, 0);
        chk("short_vblnk_x", xpos, 200);
        frame(0, 0, 0, 0, 0, 0, 1);
        frame(0, 0, 0, 0, 0, 0, 0);

        // Reset in BLANK with a pending sample
        ms_left = 1'b0;
        vblnk = 1'b1;
        tick();
        tick();
        dummy = model_commit(0, 0, 0, 0);
        tick();
        strobe(11, 22);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mx = 400; my = 300; pv = 0; s1 = 0; s2 = 0;
        chk("mid_rst_x", xpos, 400);
        chk("mid_rst_y", ypos, 300);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_click", click, 0);
        repeat (2) begin
            tick();
            chk("mid_rst_no_commit", frame_tick, 0);
        end
        vblnk = 1'b0;
        tick();
        frame(0, 0, 0, 0, 0, 0, 0);
        chk("mid_rst_pend_cleared", xpos, 400);

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            frame($urandom_range(0, 3) == 0,
                  int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
